// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: start bit, data from an external serializer, optional parity, stop bit.
// Define UART_TX_BACK2BACK_EN to accept the next frame during the stop bit (no idle gap between frames).
module uart_tx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    input  logic                  Serial_done,
    output logic [DATA_WIDTH-1:0] S_DATA,
    output logic                  Serial_EN,
    output logic                  TX_OUT,
    output logic                  Busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state;
    logic   par_bit;
    logic   par_en_q;
    logic   accept;

    // Even parity is the XOR of the data bits; odd parity inverts it.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    always_comb begin
        accept = 1'b0;
        if (state == IDLE)
            accept = Data_Valid;
`ifdef UART_TX_BACK2BACK_EN
        if (state == STOP)
            accept = Data_Valid;
`endif
    end

    // Load strobe is combinational so the serializer sees it in the acceptance cycle; gated off in reset.
    assign Serial_EN = accept & RST;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            S_DATA   <= '0;
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
        end else if (accept) begin
            S_DATA   <= P_DATA;
            par_en_q <= PAR_EN;
            par_bit  <= calc_parity(P_DATA, PAR_TYP);
            state    <= START;
        end else begin
            case (state)
                IDLE:    state <= IDLE;
                START:   state <= DATA;
                DATA:    if (Serial_done) state <= par_en_q ? PARITY : STOP;
                PARITY:  state <= STOP;
                STOP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (state)
            IDLE:    TX_OUT = 1'b1;
            START:   TX_OUT = 1'b0;
            DATA:    TX_OUT = ser_data;
            PARITY:  TX_OUT = par_bit;
            STOP:    TX_OUT = 1'b1;
            default: TX_OUT = 1'b1;
        endcase
    end

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm with a behavioural serializer; expectations are hand-computed frames.
module tb_uart_tx_fsm;
    localparam int DW = 8;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          ser_data;
    logic          Serial_done;
    logic [DW-1:0] S_DATA;
    logic          Serial_EN;
    logic          TX_OUT;
    logic          Busy;

    int tests = 0;
    int fails = 0;

    uart_tx_fsm #(.DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data),
        .Serial_done(Serial_done), .S_DATA(S_DATA), .Serial_EN(Serial_EN),
        .TX_OUT(TX_OUT), .Busy(Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Serializer model: loads one cycle after the strobe, shifts LSB first, optionally stretches done.
    logic          ser_pend;
    logic          ser_act;
    int            ser_idx;
    int            ser_extra = 0;
    logic [DW-1:0] ser_sh;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ser_pend <= 1'b0;
            ser_act  <= 1'b0;
            ser_idx  <= 0;
        end else begin
            ser_pend <= Serial_EN;
            if (ser_pend) begin
                ser_act <= 1'b1;
                ser_idx <= 0;
            end else if (ser_act) begin
                if (Serial_done) ser_act <= 1'b0;
                else             ser_idx <= ser_idx + 1;
            end
        end
    end

    always_comb begin
        ser_sh      = S_DATA >> ser_idx;
        ser_data    = 1'b0;
        Serial_done = 1'b0;
        if (ser_act) begin
            ser_data    = (ser_idx < DW) ? ser_sh[0] : ser_idx[0];
            Serial_done = (ser_idx == DW - 1 + ser_extra);
        end
    end

    // Per-cycle stimulus tables and captured outputs (first cycle ends up in the MSB of the used bits).
    logic          dv_v [64];
    logic [DW-1:0] pd_v [64];
    logic          pe_v [64];
    logic          pt_v [64];
    logic [DW-1:0] sd_c [64];
    logic [63:0]   tx_c, bz_c, se_c;
    logic [63:0]   exp_tx, exp_bz, exp_se;

    task automatic fill(input logic [DW-1:0] d, input logic pe, input logic pt);
        for (int i = 0; i < 64; i++) begin
            dv_v[i] = 1'b0;
            pd_v[i] = d;
            pe_v[i] = pe;
            pt_v[i] = pt;
        end
    endtask

    // Called at posedge+1; drives each row, samples at posedge+2, returns at posedge+1.
    task automatic run(input int n);
        tx_c = '0;
        bz_c = '0;
        se_c = '0;
        for (int i = 0; i < n; i++) begin
            Data_Valid = dv_v[i];
            P_DATA     = pd_v[i];
            PAR_EN     = pe_v[i];
            PAR_TYP    = pt_v[i];
            #1;
            tx_c    = {tx_c[62:0], TX_OUT};
            bz_c    = {bz_c[62:0], Busy};
            se_c    = {se_c[62:0], Serial_EN};
            sd_c[i] = S_DATA;
            @(posedge CLK);
            #1;
        end
        Data_Valid = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b0; Data_Valid = 1'b1; P_DATA = 8'hFF; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        tests++; if (TX_OUT !== 1'b1)    begin fails++; $display("FAIL reset_tx got %b want 1", TX_OUT); end
        tests++; if (Busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got %b want 0", Busy); end
        tests++; if (Serial_EN !== 1'b0) begin fails++; $display("FAIL reset_sen got %b want 0", Serial_EN); end
        tests++; if (S_DATA !== 8'h00)   begin fails++; $display("FAIL reset_sdata got %h want 00", S_DATA); end
        Data_Valid = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        tests++; if (Busy !== 1'b0 || TX_OUT !== 1'b1) begin
            fails++; $display("FAIL idle_after_reset busy=%b tx=%b want 0/1", Busy, TX_OUT);
        end
    endtask

    task automatic test_even_parity;
        fill(8'hA5, 1'b1, 1'b0); dv_v[0] = 1'b1;
        run(13);
        exp_tx = 64'(13'b1_0_10100101_0_1_1);
        exp_bz = 64'({1'b0, {11{1'b1}}, 1'b0});
        exp_se = 64'({1'b1, 12'b0});
        tests++; if (tx_c !== exp_tx) begin fails++; $display("FAIL even_tx got %h want %h", tx_c, exp_tx); end
        tests++; if (bz_c !== exp_bz) begin fails++; $display("FAIL even_busy got %h want %h", bz_c, exp_bz); end
        tests++; if (se_c !== exp_se) begin fails++; $display("FAIL even_sen got %h want %h", se_c, exp_se); end
        tests++; if (S_DATA !== 8'hA5) begin fails++; $display("FAIL even_sdata got %h want a5", S_DATA); end
    endtask

    task automatic test_odd_parity;
        fill(8'hA5, 1'b1, 1'b1); dv_v[0] = 1'b1;
        run(13);
        exp_tx = 64'(13'b1_0_10100101_1_1_1);
        exp_bz = 64'({1'b0, {11{1'b1}}, 1'b0});
        tests++; if (tx_c !== exp_tx) begin fails++; $display("FAIL odd_tx got %h want %h", tx_c, exp_tx); end
        tests++; if (bz_c !== exp_bz) begin fails++; $display("FAIL odd_busy got %h want %h", bz_c, exp_bz); end
    endtask

    task automatic test_no_parity;
        fill(8'hA5, 1'b0, 1'b0); dv_v[0] = 1'b1;
        run(12);
        exp_tx = 64'(12'b1_0_10100101_1_1);
        exp_bz = 64'({1'b0, {10{1'b1}}, 1'b0});
        tests++; if (tx_c !== exp_tx) begin fails++; $display("FAIL nopar_tx got %h want %h", tx_c, exp_tx); end
        tests++; if (bz_c !== exp_bz) begin fails++; $display("FAIL nopar_busy got %h want %h", bz_c, exp_bz); end
    endtask

    task automatic test_hold_dv;
        int bad;
        fill(8'h3C, 1'b0, 1'b1);
        pd_v[0] = 8'hA5; pe_v[0] = 1'b1; pt_v[0] = 1'b0;
        for (int i = 0; i <= 10; i++) dv_v[i] = 1'b1;
        run(13);
        exp_tx = 64'(13'b1_0_10100101_0_1_1);
        exp_se = 64'({1'b1, 12'b0});
        bad = 0;
        for (int i = 1; i < 13; i++) if (sd_c[i] !== 8'hA5) bad++;
        tests++; if (tx_c !== exp_tx) begin fails++; $display("FAIL hold_tx got %h want %h", tx_c, exp_tx); end
        tests++; if (se_c !== exp_se) begin fails++; $display("FAIL hold_sen got %h want %h", se_c, exp_se); end
        tests++; if (bad != 0) begin fails++; $display("FAIL hold_sdata_stable got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_reset_mid;
        fill(8'hA5, 1'b1, 1'b0); dv_v[0] = 1'b1;
        run(5);
        tests++; if (Busy !== 1'b1 || TX_OUT !== 1'b0) begin
            fails++; $display("FAIL mid_bit3 busy=%b tx=%b want 1/0", Busy, TX_OUT);
        end
        Data_Valid = 1'b1;
        RST = 1'b0;
        #1;
        tests++; if (TX_OUT !== 1'b1)    begin fails++; $display("FAIL mid_rst_tx got %b want 1", TX_OUT); end
        tests++; if (Busy !== 1'b0)      begin fails++; $display("FAIL mid_rst_busy got %b want 0", Busy); end
        tests++; if (Serial_EN !== 1'b0) begin fails++; $display("FAIL mid_rst_sen got %b want 0", Serial_EN); end
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
        RST = 1'b1;
        fill(8'h0F, 1'b1, 1'b0); dv_v[0] = 1'b1;
        run(13);
        exp_tx = 64'(13'b1_0_11110000_0_1_1);
        exp_bz = 64'({1'b0, {11{1'b1}}, 1'b0});
        exp_se = 64'({1'b1, 12'b0});
        tests++; if (tx_c !== exp_tx) begin fails++; $display("FAIL post_rst_tx got %h want %h", tx_c, exp_tx); end
        tests++; if (bz_c !== exp_bz) begin fails++; $display("FAIL post_rst_busy got %h want %h", bz_c, exp_bz); end
        tests++; if (se_c !== exp_se) begin fails++; $display("FAIL post_rst_sen got %h want %h", se_c, exp_se); end
    endtask

    task automatic test_back_to_back;
        fill(8'h55, 1'b1, 1'b0);
        for (int i = 11; i < 64; i++) pd_v[i] = 8'hAA;
        dv_v[0]  = 1'b1;
        dv_v[11] = 1'b1;
`ifdef UART_TX_BACK2BACK_EN
        run(25);
        exp_tx = 64'(25'b1_0_10101010_0_1_0_01010101_0_1_1_1);
        exp_bz = 64'({1'b0, {22{1'b1}}, 2'b00});
        exp_se = 64'({1'b1, 10'b0, 1'b1, 13'b0});
`else
        dv_v[12] = 1'b1;
        run(25);
        exp_tx = 64'(25'b1_0_10101010_0_1_1_0_01010101_0_1_1);
        exp_bz = 64'({1'b0, {11{1'b1}}, 1'b0, {11{1'b1}}, 1'b0});
        exp_se = 64'({1'b1, 11'b0, 1'b1, 12'b0});
`endif
        tests++; if (tx_c !== exp_tx) begin fails++; $display("FAIL b2b_tx got %h want %h", tx_c, exp_tx); end
        tests++; if (bz_c !== exp_bz) begin fails++; $display("FAIL b2b_busy got %h want %h", bz_c, exp_bz); end
        tests++; if (se_c !== exp_se) begin fails++; $display("FAIL b2b_sen got %h want %h", se_c, exp_se); end
    endtask

    task automatic test_delayed_done;
        ser_extra = 3;
        fill(8'hA5, 1'b1, 1'b0); dv_v[0] = 1'b1;
        run(16);
        ser_extra = 0;
        exp_tx = 64'({1'b1, 14'b0_10100101_010_0_1, 1'b1});
        exp_bz = 64'({1'b0, {14{1'b1}}, 1'b0});
        tests++; if (tx_c !== exp_tx) begin fails++; $display("FAIL delay_tx got %h want %h", tx_c, exp_tx); end
        tests++; if (bz_c !== exp_bz) begin fails++; $display("FAIL delay_busy got %h want %h", bz_c, exp_bz); end
    endtask

    initial begin
        test_reset;
        test_even_parity;
        test_odd_parity;
        test_no_parity;
        test_hold_dv;
        test_reset_mid;
        test_back_to_back;
        test_delayed_done;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_fsm.md
UART_TX_FSM -- requirements
Module: uart_tx_fsm

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, frame data bit count.
REQ-002 CLK  input  1  baud-rate bit clock; all state changes on rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 P_DATA  input  DATA_WIDTH  parallel byte to send; sampled only on frame acceptance.
REQ-005 Data_Valid  input  1  request to send P_DATA.
REQ-006 PAR_EN  input  1  1 = parity bit inserted between data and stop; sampled on acceptance.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd; sampled on acceptance.
REQ-008 ser_data  input  1  serial data bit from the serializer.
REQ-009 Serial_done  input  1  serializer flag; high in the cycle its last data bit is on ser_data.
REQ-010 S_DATA  output  DATA_WIDTH  latched frame data presented to the serializer.
REQ-011 Serial_EN  output  1  one-cycle load strobe to the serializer.
REQ-012 TX_OUT  output  1  UART line output.
REQ-013 Busy  output  1  high while a frame is in progress.

Function
REQ-014 States: IDLE, START, DATA, PARITY, STOP; one CLK cycle per bit, except DATA.
REQ-015 IDLE with Data_Valid=1 (acceptance): latch P_DATA into S_DATA, latch PAR_EN/PAR_TYP, compute parity, assert Serial_EN combinationally this cycle, next state START.
REQ-016 IDLE with Data_Valid=0: remain IDLE, Serial_EN=0.
REQ-017 START: one cycle, next state DATA.
REQ-018 DATA: remain until Serial_done=1; then PARITY if latched PAR_EN=1, else STOP.
REQ-019 PARITY: one cycle, next STOP.
REQ-020 STOP: one cycle, next IDLE (see REQ-031/032).
REQ-021 Parity bit: even = XOR of all S_DATA bits; odd = its inverse; registered at acceptance.
REQ-022 TX_OUT per state: IDLE 1, START 0, DATA ser_data, PARITY parity bit, STOP 1; decoded from registered state/parity and ser_data only.
REQ-023 Busy = 1 in every state except IDLE.
REQ-024 Data_Valid, P_DATA, PAR_EN, PAR_TYP ignored while Busy=1 (outside REQ-031); S_DATA stable for the whole frame.
REQ-025 Serial_done outside DATA is ignored.
REQ-026 Frame length (START through STOP): DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity, given serializer contract in REQ-009.
REQ-027 Serial_EN asserted only in the acceptance cycle; never two consecutive cycles.

Reset
REQ-028 RST low: state IDLE, S_DATA 0, parity register 0, latched PAR_EN/PAR_TYP 0.
REQ-029 Outputs during/after reset: TX_OUT 1, Busy 0, Serial_EN 0.
REQ-030 Reset mid-frame aborts the frame immediately; no partial bits resume after release; first accept allowed on first edge after release.

Configuration
REQ-031 Macro UART_TX_BACK2BACK_EN defined: in STOP with Data_Valid=1, perform acceptance per REQ-015 (Serial_EN pulse, latch) and go directly to START; Busy stays high, no IDLE cycle between frames.
REQ-032 Macro UART_TX_BACK2BACK_EN undefined: STOP always goes to IDLE; Data_Valid in STOP ignored; minimum one idle (TX_OUT=1) cycle between frames.

Verification
REQ-033 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle Data_Valid -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; Busy high exactly 11 cycles; Serial_EN one pulse.
REQ-034 Same with PAR_TYP=1 -> parity bit 1; with PAR_EN=0 -> 10-cycle frame ending 0x1 stop, no parity slot.
REQ-035 Data_Valid held high with P_DATA changed to 0x3C mid-frame -> frame still carries 0xA5; S_DATA unchanged until next acceptance.
REQ-036 RST asserted during DATA (4th data bit) -> TX_OUT=1, Busy=0 same cycle; after release Data_Valid with 0x0F sends a clean full frame.
REQ-037 Back-to-back 0x55 then 0xAA, Data_Valid high in STOP -> with UART_TX_BACK2BACK_EN: START of second frame immediately after stop, 22 contiguous Busy cycles (parity on); without: one TX_OUT=1 idle cycle, second frame accepted from IDLE.
REQ-038 Serial_done delayed 3 extra cycles by serializer model -> FSM holds DATA, TX_OUT follows ser_data, then proceeds to PARITY/STOP normally.
